utm_core: RTL and testbench
===========================

# utm_core

Single-step transition engine for the (2,3) universal Turing machine. Each accepted symbol from the tape controller is looked up against the current machine state, and the block returns three results: the symbol to write, the head move direction and the next state. It sits between the tape memory/head controller and the run-control logic. The state is either held internally (run mode) or supplied externally (lookup mode).

## Interface
- Parameters: none.
- `clock`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mode`  in  1  state source select; 1 = internal state register, 0 = external `encoded_state_in`.
- `encoded_state_in`  in  3  binary-encoded state used when `mode`=0.
- `sym_in`  in  3  one-hot tape symbol read under the head.
- `sym_in_valid`  in  1  single-cycle strobe marking `sym_in` as valid.
- `new_sym`  out  3  one-hot symbol to write, registered.
- `direction`  out  1  head move, registered; 1 = right, 0 = left.
- `encoded_next_state`  out  3  binary-encoded next state, registered.

## Operation
- Symbol encoding (one-hot): S0 = 3'b001 (blank), S1 = 3'b010, S2 = 3'b100. Any other value is invalid.
- State encoding (binary):
  - A = 3'd0.
  - B = 3'd1.
  - HALT = 3'd7 (error/stop).
  - Values 2..6 are invalid.
- Current state: the internal register `state_q` when `mode`=1; `encoded_state_in` when `mode`=0.
- Transition table (current state, symbol -> write, move, next):
  - A,S0 -> S1, R, B
  - A,S1 -> S2, L, A
  - A,S2 -> S1, L, A
  - B,S0 -> S2, L, A
  - B,S1 -> S2, R, B
  - B,S2 -> S0, R, A
- Error cases:
  - Invalid symbol, or current state is HALT or 2..6: `new_sym` = `sym_in` unchanged, `direction` = 0, next = HALT.
- On a cycle with `sym_in_valid`=1:
  - The table result loads into all three output registers.
  - `state_q` loads the next state in both modes, so switching to `mode`=1 continues from the last step.
- With `sym_in_valid`=0, all registers hold.
- HALT is sticky in `mode`=1. Only reset, or a `mode`=0 lookup with a valid external state, leaves it.
- `mode` is only sampled together with `sym_in_valid`. Toggling it while idle has no effect.

## Timing
- Reset (async assert, synchronous release):
  - `state_q` = A (3'd0).
  - `new_sym` = 3'b001.
  - `direction` = 0.
  - `encoded_next_state` = 3'd0.
- Latency: outputs update on the same rising edge that samples `sym_in_valid`=1. They are valid from that edge until the next accepted strobe.
- Throughput: one step per cycle. `sym_in_valid` held high for N cycles performs N consecutive steps, each chained through `state_q` in `mode`=1.
- There is no backpressure and no busy signal. The block is always ready.
- Reset asserted mid-operation: all registers return to reset values immediately, regardless of the clock. A strobe coincident with reset release is ignored.
- Inputs must be stable around the sampling edge. The bench drives them on the falling edge.

## Test plan
- Reset check: hold `reset`=0 for 5 cycles, then release.
  - Required: `new_sym`=001, `direction`=0, `encoded_next_state`=0.
  - These values hold for 5 idle cycles.
- Run-mode chain: `mode`=1, with one-cycle strobes spaced 10 cycles apart.
  - sym 001 -> 010 / 1 / 1.
  - sym 001 -> 100 / 0 / 0.
  - sym 010 -> 100 / 0 / 0.
  - sym 010 -> 100 / 0 / 0.
  - Outputs must hold between strobes.
- Lookup mode: `mode`=0, `encoded_state_in`=1, sym 100.
  - Required: 001 / 1 / 0.
  - Then `mode`=1 with sym 001 yields 010 / 1 / 1, continuing from state A.
- Error handling, invalid symbol: sym 011 in state A.
  - Required: 011 / 0 / 7.
  - A following valid sym 001 with `mode`=1 stays at next=7.
- Error handling, invalid external state: `mode`=0, `encoded_state_in`=5, sym 001.
  - Required: 001 / 0 / 7.
- Back-to-back steps and reset mid-run: `sym_in_valid` held high 3 cycles with sym 001, starting from A.
  - States must step B, A, B.
  - Asserting reset asynchronously between edges clears all outputs to reset values at once.

Source files
------------

// File: rtl/utm_core.sv
// Single-step transition engine for the (2,3) universal Turing machine.
// Each accepted symbol is mapped to a write symbol, head move and next state.
module utm_core (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic [2:0] encoded_state_in,
  input  logic [2:0] sym_in,
  input  logic       sym_in_valid,
  output logic [2:0] new_sym,
  output logic       direction,
  output logic [2:0] encoded_next_state
);

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_B    = 3'd1,
    ST_HALT = 3'd7
  } state_t;

  localparam logic [2:0] SYM_0 = 3'b001;
  localparam logic [2:0] SYM_1 = 3'b010;
  localparam logic [2:0] SYM_2 = 3'b100;

  state_t     state_q;
  logic [2:0] cur_state;
  logic       sym_ok;
  logic [2:0] nxt_sym;
  logic       nxt_dir;
  state_t     nxt_state;

  // Anything outside the table (bad symbol, HALT, states 2..6) echoes the
  // symbol, moves left and drops into HALT.
  always_comb begin
    cur_state = mode ? state_q : encoded_state_in;
    sym_ok    = (sym_in == SYM_0) || (sym_in == SYM_1) || (sym_in == SYM_2);
    nxt_sym   = sym_in;
    nxt_dir   = 1'b0;
    nxt_state = ST_HALT;
    if (sym_ok) begin
      case (cur_state)
        ST_A: begin
          case (sym_in)
            SYM_0: begin nxt_sym = SYM_1; nxt_dir = 1'b1; nxt_state = ST_B; end
            SYM_1: begin nxt_sym = SYM_2; nxt_dir = 1'b0; nxt_state = ST_A; end
            default: begin nxt_sym = SYM_1; nxt_dir = 1'b0; nxt_state = ST_A; end
          endcase
        end
        ST_B: begin
          case (sym_in)
            SYM_0: begin nxt_sym = SYM_2; nxt_dir = 1'b0; nxt_state = ST_A; end
            SYM_1: begin nxt_sym = SYM_2; nxt_dir = 1'b1; nxt_state = ST_B; end
            default: begin nxt_sym = SYM_0; nxt_dir = 1'b1; nxt_state = ST_A; end
          endcase
        end
        default: begin
          nxt_sym   = sym_in;
          nxt_dir   = 1'b0;
          nxt_state = ST_HALT;
        end
      endcase
    end
  end

  // The internal state follows every accepted step, even in lookup mode,
  // so switching to run mode picks up from the last result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q            <= ST_A;
      new_sym            <= SYM_0;
      direction          <= 1'b0;
      encoded_next_state <= 3'd0;
    end else if (sym_in_valid) begin
      state_q            <= nxt_state;
      new_sym            <= nxt_sym;
      direction          <= nxt_dir;
      encoded_next_state <= nxt_state;
    end
  end

endmodule

// File: tb/tb_utm_core.sv
// Self-checking bench for utm_core: directed scenarios plus randomized steps
// compared against a table-driven machine model.
module tb_utm_core;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] encoded_state_in = 3'd0;
  logic [2:0] sym_in = 3'b001;
  logic       sym_in_valid = 1'b0;
  logic [2:0] new_sym;
  logic       direction;
  logic [2:0] encoded_next_state;

  int total = 0;
  int bad = 0;

  logic [2:0] model_state;
  logic [6:0] model_exp;
  logic [6:0] observed;

  // Machine table indexed by state*3 + symbol number.
  logic [2:0] write_tab [6] = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b100, 3'b001};
  logic       move_tab  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [2:0] next_tab  [6] = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};

  utm_core dut (
    .clock              (clock),
    .reset              (reset),
    .mode               (mode),
    .encoded_state_in   (encoded_state_in),
    .sym_in             (sym_in),
    .sym_in_valid       (sym_in_valid),
    .new_sym            (new_sym),
    .direction          (direction),
    .encoded_next_state (encoded_next_state)
  );

  assign observed = {new_sym, direction, encoded_next_state};

  always #5 clock = ~clock;

  function automatic logic [6:0] model_step(input logic [2:0] st, input logic [2:0] sym);
    int idx;
    int k;
    idx = -1;
    if (sym == 3'b001) idx = 0;
    else if (sym == 3'b010) idx = 1;
    else if (sym == 3'b100) idx = 2;
    if (idx < 0 || st > 3'd1) return {sym, 1'b0, 3'd7};
    k = int'(st) * 3 + idx;
    return {write_tab[k], move_tab[k], next_tab[k]};
  endfunction

  task automatic check_output(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got sym=%b dir=%b next=%0d, expected sym=%b dir=%b next=%0d",
               tag, got[6:4], got[3], got[2:0], exp[6:4], exp[3], exp[2:0]);
    end
  endtask

  // Drives one strobe from a falling edge and returns on the next falling edge.
  task automatic apply_stimulus(input logic m, input logic [2:0] st, input logic [2:0] sym);
    logic [2:0] cur;
    mode             = m;
    encoded_state_in = st;
    sym_in           = sym;
    sym_in_valid     = 1'b1;
    cur              = m ? model_state : st;
    model_exp        = model_step(cur, sym);
    model_state      = model_exp[2:0];
    @(negedge clock);
    sym_in_valid     = 1'b0;
  endtask

  // Idle cycles with junk on the non-strobe inputs; nothing may change.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mode             = 1'($urandom_range(0, 1));
      encoded_state_in = 3'($urandom_range(0, 7));
      sym_in           = 3'($urandom_range(0, 7));
      @(negedge clock);
    end
  endtask

  initial begin
    model_state = 3'd0;
    model_exp   = {3'b001, 1'b0, 3'd0};

    repeat (5) @(negedge clock);
    check_output("reset_held", observed, {3'b001, 1'b0, 3'd0});
    reset = 1'b1;
    idle(5);
    check_output("reset_idle", observed, {3'b001, 1'b0, 3'd0});

    apply_stimulus(1'b1, 3'd0, 3'b001);
    check_output("chain1", observed, {3'b010, 1'b1, 3'd1});
    idle(9);
    check_output("chain1_hold", observed, {3'b010, 1'b1, 3'd1});
    apply_stimulus(1'b1, 3'd0, 3'b001);
    check_output("chain2", observed, {3'b100, 1'b0, 3'd0});
    idle(9);
    apply_stimulus(1'b1, 3'd6, 3'b010);
    check_output("chain3", observed, {3'b100, 1'b0, 3'd0});
    idle(9);
    check_output("chain3_hold", observed, {3'b100, 1'b0, 3'd0});
    apply_stimulus(1'b1, 3'd0, 3'b010);
    check_output("chain4", observed, {3'b100, 1'b0, 3'd0});
    idle(9);

    apply_stimulus(1'b0, 3'd1, 3'b100);
    check_output("lookup_b_s2", observed, {3'b001, 1'b1, 3'd0});
    idle(3);
    apply_stimulus(1'b1, 3'd5, 3'b001);
    check_output("lookup_then_run", observed, {3'b010, 1'b1, 3'd1});
    idle(3);

    apply_stimulus(1'b0, 3'd0, 3'b011);
    check_output("bad_sym", observed, {3'b011, 1'b0, 3'd7});
    idle(3);
    apply_stimulus(1'b1, 3'd0, 3'b001);
    check_output("halt_sticky", observed, {3'b001, 1'b0, 3'd7});
    idle(3);
    apply_stimulus(1'b0, 3'd5, 3'b001);
    check_output("bad_state", observed, {3'b001, 1'b0, 3'd7});
    idle(3);

    apply_stimulus(1'b0, 3'd0, 3'b010);
    check_output("leave_halt", observed, {3'b100, 1'b0, 3'd0});
    apply_stimulus(1'b1, 3'd0, 3'b001);
    check_output("b2b_1", observed, {3'b010, 1'b1, 3'd1});
    apply_stimulus(1'b1, 3'd0, 3'b001);
    check_output("b2b_2", observed, {3'b100, 1'b0, 3'd0});
    apply_stimulus(1'b1, 3'd0, 3'b001);
    check_output("b2b_3", observed, {3'b010, 1'b1, 3'd1});

    @(posedge clock);
    #2 reset = 1'b0;
    #1 check_output("async_reset", observed, {3'b001, 1'b0, 3'd0});
    model_state = 3'd0;
    model_exp   = {3'b001, 1'b0, 3'd0};
    @(negedge clock);
    reset = 1'b1;
    idle(2);
    check_output("after_reset", observed, model_exp);
    apply_stimulus(1'b1, 3'd0, 3'b001);
    check_output("restart_from_a", observed, {3'b010, 1'b1, 3'd1});

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        logic [2:0] st;
        logic [2:0] sym;
        st  = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
        case ($urandom_range(0, 7))
          0:       sym = 3'($urandom_range(0, 7));
          1, 2, 3: sym = 3'b001;
          4, 5:    sym = 3'b010;
          default: sym = 3'b100;
        endcase
        apply_stimulus(1'($urandom_range(0, 1)), st, sym);
        check_output("rand_step", observed, model_exp);
      end else begin
        idle(int'($urandom_range(1, 3)));
        check_output("rand_hold", observed, model_exp);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
